thumb_fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the emulator's decode/execute stage. It reads 32-bit words from instruction memory and splits each word into 16-bit Thumb halfwords. It delivers one halfword per cycle over a valid/ready handshake, together with the halfword's byte PC. It also accepts branch redirects from execute, flushing buffered and in-flight fetches.

---
 rtl/emu_pkg.sv | 14 +
 rtl/fetch_word_queue.sv | 51 +++++
 rtl/thumb_fetch_unit.sv | 85 ++++++++
 3 files changed

// File: rtl/emu_pkg.sv
// Shared widths, reset PC and halfword-select helper for the Thumb fetch path.
package emu_pkg;
  localparam int INST_W = 16;
  localparam int WORD_W = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // pc[1] picks the halfword; Thumb is little-endian within a word
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  function automatic logic [INST_W-1:0] select_half(input logic [WORD_W-1:0] word, input logic sel);
    return (sel == HALF_HI) ? word[WORD_W-1:INST_W] : word[INST_W-1:0];
  endfunction
endpackage

// File: rtl/fetch_word_queue.sv
// Two-entry word FIFO with flush; a pushed word is the head one cycle later.
// No backpressure output: the producer must track credits, push into a full queue fires an assertion.
module fetch_word_queue
  import emu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_dat,
  input  logic              pop,
  input  logic              flush,
  output logic [WORD_W-1:0] head_dat,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] slot [2];
  logic              rd_ptr;
  logic              wr_ptr;

  assign head_dat = slot[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      slot[0] <= '0;
      slot[1] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // when full, push+pop writes the slot being popped; the head was already consumed
      if (push) begin
        slot[wr_ptr] <= push_dat;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && !flush && count == 2'd2));
  a_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(pop && !flush && count == 2'd0));
endmodule

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch: requests 32-bit words, presents one halfword per cycle with its byte PC; request to inst_valid is 2 cycles.
// inst holds while inst_ready is low; requests stop once queued plus in-flight words reach two.
module thumb_fetch_unit
  import emu_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc
);
  logic [31:0]       pc;
  logic [ADDR_W-1:0] fetch_ptr;
  logic              inflight;
  logic              inflight_epoch;
  logic              epoch;
  logic [WORD_W-1:0] head_dat;
  logic [1:0]        q_count;
  logic              credit_ok;
  logic              accept;
  logic              fire;
  logic              pop;
  logic              unused_pc_bit;

  assign unused_pc_bit = redirect_pc[0];

  assign credit_ok = (3'(q_count) + 3'(inflight)) < 3'd2;
  assign mem_req   = reset_n && !redirect && credit_ok;
  assign mem_addr  = fetch_ptr;

  // responses tagged with an older epoch belong to a squashed fetch stream
  assign accept = mem_rvalid && inflight && (inflight_epoch == epoch) && !redirect;

  assign inst_valid = (q_count != 2'd0);
  assign inst       = select_half(head_dat, pc[1]);
  assign inst_pc    = pc;
  assign fire       = inst_valid && inst_ready;
  assign pop        = fire && (pc[1] == HALF_HI) && !redirect;

  fetch_word_queue u_queue (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (accept),
    .push_dat (mem_rdata),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .count    (q_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      fetch_ptr      <= RESET_PC[ADDR_W+1:2];
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
    end else begin
      if (redirect) begin
        pc        <= {redirect_pc[31:1], 1'b0};
        fetch_ptr <= redirect_pc[ADDR_W+1:2];
        epoch     <= ~epoch;
      end else begin
        if (fire) pc <= pc + 32'd2;
        if (mem_req) fetch_ptr <= fetch_ptr + 1'b1;
      end
      if (mem_req) begin
        inflight       <= 1'b1;
        inflight_epoch <= epoch;
      end else if (mem_rvalid) begin
        inflight <= 1'b0;
      end
    end
  end
endmodule
